// File: rtl/pim_matmul_engine.sv
// Operand-to-result matrix multiply engine.
// Latches two m x m operands, sweeps the result elements in batches of P
// lanes (one MAC per lane per cycle, m cycles per batch) and holds the result
// until the write-back side accepts it.
module pim_matmul_engine #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned N        = 4,
  parameter int unsigned NUM_PIMS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             matrix_size,
  input  logic [2:0]             no_of_pims,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*N*WIDTH-1:0]   a_flat,
  input  logic [N*N*WIDTH-1:0]   b_flat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*N*WIDTH-1:0]   c_flat,
  output logic                   busy
);

  localparam int unsigned FW = N * N * WIDTH;
  localparam int unsigned MW = $clog2(N + 1);
  localparam int unsigned PW = $clog2(NUM_PIMS + 1);
  // Element index must hold base + lane offset past the last element.
  localparam int unsigned EW = $clog2(N * N + NUM_PIMS + 1);

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e            state_q, state_d;
  logic [FW-1:0]     a_q, b_q, c_q;
  logic [MW-1:0]     m_q, k_q;
  logic [PW-1:0]     p_q;
  logic [EW-1:0]     base_q;
  logic [WIDTH-1:0]  acc_q [NUM_PIMS];

  logic [MW-1:0]     m_cfg;
  logic [PW-1:0]     p_cfg;
  logic [EW-1:0]     mm;
  logic              last_k;
  logic              last_batch;
  logic              accept;

  logic [NUM_PIMS-1:0] lane_act;
  logic [EW-1:0]       lane_e   [NUM_PIMS];
  logic [WIDTH-1:0]    lane_sum [NUM_PIMS];

  // Clamp the requested configuration into the supported range.
  always_comb begin
    m_cfg = MW'(N);
    if (matrix_size != '0 && 32'(matrix_size) <= N) m_cfg = MW'(matrix_size);
    p_cfg = PW'(NUM_PIMS);
    if (no_of_pims == '0) begin
      p_cfg = PW'(1);
    end else if (32'(no_of_pims) <= NUM_PIMS) begin
      p_cfg = PW'(no_of_pims);
    end
  end

  // Loop bookkeeping shared by all lanes.
  always_comb begin
    mm         = EW'(m_q) * EW'(m_q);
    last_k     = (k_q == m_q - 1'b1);
    last_batch = ((base_q + EW'(p_q)) >= mm);
  end

  // Per-lane operand fetch and multiply-accumulate; wraps modulo 2^WIDTH,
  // so only the low WIDTH bits of each product are ever needed.
  always_comb begin
    logic [EW-1:0]    row, col, a_idx, b_idx;
    logic [WIDTH-1:0] a_el, b_el, prod;
    row   = '0;
    col   = '0;
    a_idx = '0;
    b_idx = '0;
    a_el  = '0;
    b_el  = '0;
    prod  = '0;
    for (int l = 0; l < NUM_PIMS; l++) begin
      lane_e[l]   = base_q + EW'(l);
      lane_act[l] = (EW'(l) < EW'(p_q)) && (lane_e[l] < mm);
      row         = lane_e[l] / EW'(m_q);
      col         = lane_e[l] % EW'(m_q);
      if (lane_act[l]) begin
        a_idx = row * EW'(m_q) + EW'(k_q);
        b_idx = EW'(k_q) * EW'(m_q) + col;
      end else begin
        // Keep idle lanes' selects inside the bus.
        a_idx = '0;
        b_idx = '0;
      end
      a_el        = a_q[a_idx*WIDTH +: WIDTH];
      b_el        = b_q[b_idx*WIDTH +: WIDTH];
      prod        = a_el * b_el;
      lane_sum[l] = acc_q[l] + prod;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = StCompute;
        end
      end
      StCompute: begin
        busy = 1'b1;
        if (last_k && last_batch) state_d = StDone;
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture, accumulation and result write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      m_q    <= MW'(N);
      p_q    <= PW'(1);
      k_q    <= '0;
      base_q <= '0;
      for (int l = 0; l < NUM_PIMS; l++) acc_q[l] <= '0;
    end else if (accept) begin
      a_q    <= a_flat;
      b_q    <= b_flat;
      c_q    <= '0;
      m_q    <= m_cfg;
      p_q    <= p_cfg;
      k_q    <= '0;
      base_q <= '0;
      for (int l = 0; l < NUM_PIMS; l++) acc_q[l] <= '0;
    end else if (state_q == StCompute) begin
      if (last_k) begin
        k_q    <= '0;
        base_q <= base_q + EW'(p_q);
        for (int l = 0; l < NUM_PIMS; l++) begin
          acc_q[l] <= '0;
          if (lane_act[l]) c_q[lane_e[l]*WIDTH +: WIDTH] <= lane_sum[l];
        end
      end else begin
        k_q <= k_q + 1'b1;
        for (int l = 0; l < NUM_PIMS; l++) begin
          if (lane_act[l]) acc_q[l] <= lane_sum[l];
        end
      end
    end
  end

  assign c_flat = c_q;

endmodule

// File: tb/tb_pim_matmul_engine.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops and
// compares result and accept-to-valid latency whenever out_valid rises.
module tb_pim_matmul_engine;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned N        = 4;
  localparam int unsigned NUM_PIMS = 4;
  localparam int unsigned FW       = N * N * WIDTH;

  typedef int unsigned vec_t [16];
  typedef struct {
    logic [FW-1:0] c;
    int            lat;
  } exp_t;

  logic          clk, rst;
  logic [2:0]    matrix_size, no_of_pims;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [FW-1:0] a_flat, b_flat, c_flat;

  pim_matmul_engine #(
    .WIDTH   (WIDTH),
    .N       (N),
    .NUM_PIMS(NUM_PIMS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .matrix_size(matrix_size),
    .no_of_pims (no_of_pims),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_flat     (a_flat),
    .b_flat     (b_flat),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .c_flat     (c_flat),
    .busy       (busy)
  );

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  exp_t sb [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [FW-1:0] pack(input vec_t v);
    logic [FW-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*WIDTH +: WIDTH] = WIDTH'(v[i]);
    return r;
  endfunction

  function automatic logic [FW-1:0] fill(input int unsigned x);
    logic [FW-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*WIDTH +: WIDTH] = WIDTH'(x);
    return r;
  endfunction

  task automatic check_vec(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: compare each presented result against the scoreboard head.
  initial begin
    logic prev_ov;
    exp_t e;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && in_valid && in_ready) acc_cyc = cyc;
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_out_valid: got out_valid=1 required no result pending");
        end else begin
          e = sb.pop_front();
          check_vec("result_c", c_flat, e.c);
          check_int("latency", cyc - acc_cyc - 1, e.lat);
        end
      end
      prev_ov = out_valid;
    end
  end

  // Present one operand pair and hold it until accepted.
  task automatic issue(input bit sync, input logic [2:0] ms, input logic [2:0] np,
                       input logic [FW-1:0] a, input logic [FW-1:0] b,
                       input logic [FW-1:0] exp_c, input int exp_lat, input bit expect_res);
    int n;
    if (sync) begin
      @(posedge clk);
      #1;
    end
    matrix_size = ms;
    no_of_pims  = np;
    a_flat      = a;
    b_flat      = b;
    in_valid    = 1'b1;
    if (expect_res) sb.push_back('{c: exp_c, lat: exp_lat});
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got in_ready=0 required 1");
    end
    @(posedge clk);
    #1;
    // Garbage after accept must not disturb the operation.
    in_valid    = 1'b0;
    a_flat      = fill(32'h0000_A5A5);
    b_flat      = fill(32'h0000_5A5A);
    matrix_size = 3'd1;
    no_of_pims  = 3'd1;
  endtask

  task automatic wait_result(input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (!(out_valid && out_ready) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!(out_valid && out_ready)) begin
      vectors++;
      miscompares++;
      $display("FAIL result_timeout: got no handshake required one within %0d cycles", bound);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t          va, vb, vc;
    logic [FW-1:0] ca;
    int            ov_seen;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    matrix_size = '0;
    no_of_pims = '0;
    a_flat = '0;
    b_flat = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_int("reset_in_ready", int'(in_ready), 1);
    check_int("reset_out_valid", int'(out_valid), 0);
    check_int("reset_busy", int'(busy), 0);
    check_vec("reset_c_flat", c_flat, '0);

    // m=2, P=4: A x I = A, one batch of two cycles.
    va = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vb = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    issue(1'b1, 3'd2, 3'd4, pack(va), pack(vb), pack(va), 2, 1'b1);
    wait_result(100);

    // m=4, P=3: six batches of four cycles, every element 4*2*2.
    issue(1'b1, 3'd4, 3'd3, fill(2), fill(2), fill(16), 24, 1'b1);
    wait_result(100);

    // m=3, P=1: nine batches of three cycles.
    va = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0, 0, 0, 0, 0, 0};
    vb = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0};
    vc = '{30, 24, 18, 84, 69, 54, 138, 114, 90, 0, 0, 0, 0, 0, 0, 0};
    issue(1'b1, 3'd3, 3'd1, pack(va), pack(vb), pack(vc), 27, 1'b1);
    wait_result(100);

    // Wrap with backpressure: 2*0xFFFE0001 mod 2^16 = 2; m=2, P=2 -> 4 cycles.
    out_ready = 1'b0;
    vc = '{2, 2, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    issue(1'b1, 3'd2, 3'd2, fill(32'hFFFF), fill(32'hFFFF), pack(vc), 4, 1'b1);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a_flat = fill(1);
      b_flat = fill(1);
      matrix_size = 3'd1;
      @(negedge clk);
      check_int("bp_out_valid", int'(out_valid), 1);
      check_int("bp_in_ready", int'(in_ready), 0);
      check_vec("bp_c_flat", c_flat, pack(vc));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_int("in_ready_after_release", int'(in_ready), 1);
    check_int("out_valid_after_release", int'(out_valid), 0);

    // Clamp, accepted on the cycle right after release: m=0 -> 4, P=7 -> 4.
    va = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    vb = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    ca = pack(va);
    issue(1'b0, 3'd0, 3'd7, ca, pack(vb), ca, 16, 1'b1);
    wait_result(100);

    // Reset mid-compute: long op (m=4, P=1) is abandoned.
    issue(1'b1, 3'd4, 3'd1, fill(3), fill(3), '0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_int("rst_mid_in_ready", int'(in_ready), 1);
    check_int("rst_mid_out_valid", int'(out_valid), 0);
    check_int("rst_mid_busy", int'(busy), 0);
    check_vec("rst_mid_c_flat", c_flat, '0);
    ov_seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) ov_seen = 1;
    end
    check_int("rst_mid_no_out_valid", ov_seen, 0);

    check_int("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pim_matmul_engine.md
# pim_matmul_engine

Responder side of the memory-to-PIM operand path. Accepts two square operand matrices streamed from the memory block, computes their product on a configurable number of parallel MAC lanes ("PIMs"), and returns the result matrix for write-back through a valid/ready handshake. It sits between the memory block's operand fetch and its destination write-back.

## Interface
- WIDTH, 16: element width in bits (unsigned).
- N, 4: maximum matrix dimension; sizes the flat buses.
- NUM_PIMS, 4: number of physical MAC lanes.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- matrix_size  in  3  active dimension m; sampled at accept.
- no_of_pims  in  3  active lane count P; sampled at accept.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  engine can accept operands.
- a_flat  in  N*N*WIDTH  operand A; element (i,j) at index i*m+j, bits [idx*WIDTH +: WIDTH].
- b_flat  in  N*N*WIDTH  operand B, same layout.
- out_valid  out  1  result valid.
- out_ready  in  1  memory block accepts result.
- c_flat  out  N*N*WIDTH  result C = A x B, same layout.
- busy  out  1  high in COMPUTE or DONE.

## Operation
- States: IDLE, COMPUTE, DONE.
- IDLE: in_ready=1. On in_valid && in_ready: latch a_flat, b_flat, m, P; clear c_flat; base=0, k=0; go COMPUTE.
- Config clamp at accept: m=0 or m>N -> m=N; P=0 -> 1; P>NUM_PIMS -> NUM_PIMS.
- COMPUTE: elements processed in batches; lane l (l<P) owns element e=base+l, i=e/m, j=e%m, if e<m*m; otherwise idle.
- Each cycle every active lane does acc_l += A[i][k]*B[k][j]; k increments.
- On cycle with k=m-1: lane writes acc_l + product to C[e], clears acc_l; k=0; base+=P. If base+P >= m*m go DONE, else stay.
- Arithmetic: product 2*WIDTH bits, accumulation and result truncated to low WIDTH bits (modulo 2^WIDTH, no saturation).
- DONE: out_valid=1, c_flat stable. On out_valid && out_ready go IDLE.
- c_flat indices >= m*m are 0.
- Inputs a_flat/b_flat/matrix_size/no_of_pims ignored outside the accept cycle.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, busy=0, c_flat=0, all accumulators 0.
- Reset mid-COMPUTE or mid-DONE: in-flight result discarded, state IDLE next cycle, no out_valid.
- Batches B = ceil(m*m / P); compute cycles = B*m.
- Accept at edge E0 -> out_valid rises at edge E0 + B*m.
- in_ready deasserts the edge after accept; in_ready=0 throughout COMPUTE and DONE.
- out_valid held until out_ready; result handshake at edge E1 -> in_ready=1 from E1; next accept earliest at E1+1 edge.
- No overlap of operations; in_valid during COMPUTE/DONE is not accepted and must be held by the sender.
- out_ready while not out_valid has no effect.

## Test plan
- m=2, P=4, A=[1,2;3,4], B=identity -> out_valid exactly 2 cycles after accept, C=[1,2;3,4], c_flat[4..15]=0.
- m=4, P=3, A=B=all elements 2 -> B=6 batches, out_valid 24 cycles after accept, all 16 elements =16.
- m=3, P=1, A=[1..9], B=[9..1] row-major -> out_valid 27 cycles after accept, C row0=[30,24,18], row2=[138,114,90].
- Backpressure: out_ready=0 for 10 cycles after out_valid -> c_flat/out_valid stable, in_ready=0, in_valid ignored; then out_ready=1 -> IDLE, next op accepted the following cycle.
- Wrap: WIDTH=16, m=2, all elements 0xFFFF -> each C element = 2*0xFFFE0001 mod 2^16 = 0x0002.
- Clamp/reset: matrix_size=0, no_of_pims=7 -> treated as m=4, P=4, out_valid 16 cycles after accept; rst asserted mid-COMPUTE -> out_valid never rises, in_ready=1 cycle after rst, c_flat=0.
